cache_line_fill_ctrl: RTL and testbench

//  Parametrised cache-miss line-fill controller, successor to the fixed 4-word/8-chunk fill FSM.
//  On a miss it issues pipelined word reads to memory, tracks outstanding requests with a credit counter,
//  and writes each returning word into the data array at its word index. When the last word lands it

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_up_counter.sv | 37 +++
 rtl/cache_line_fill_ctrl.sv | 128 ++++++++++++
 tb/tb_cache_line_fill_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache line-fill controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_t;

    function automatic int line_bytes(input int words_per_line, input int word_bytes);
        return words_per_line * word_bytes;
    endfunction

    function automatic int idx_w(input int words_per_line);
        return (words_per_line > 1) ? $clog2(words_per_line) : 1;
    endfunction

endpackage

// File: rtl/cache_up_counter.sv
// Async-reset counter with synchronous clear; inc and dec together leave it unchanged.
module cache_up_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Cache-miss line-fill controller: pipelined word reads bounded by an outstanding-credit
// limit, in-order write-back into the data array, then a single tag-write pulse.
module cache_line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_LINE  = 8,
    parameter int WORD_BYTES      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               mem_busy,
    input  logic                               memory_data_valid,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [idx_w(WORDS_PER_LINE)-1:0]   data_word_idx,
    output logic                               write_tag_array,
    output logic [ADDR_W-1:0]                  tag_address,
    output logic                               fsm_busy
);

    localparam int IDX_W = idx_w(WORDS_PER_LINE);
    // issue_cnt must be able to hold WORDS_PER_LINE itself to mark "all issued"
    localparam int ISS_W = IDX_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LB    = line_bytes(WORDS_PER_LINE, WORD_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LB - 1);

    fill_state_t       state_q;
    logic [ADDR_W-1:0] line_base_q;
    logic              tag_wr_q;
    logic              busy_q;

    logic [ISS_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic [OUT_W-1:0]  outstanding;

    logic in_fill;
    logic issue;
    logic accept;
    logic last_accept;
    logic clr_cnt;

    assign in_fill     = (state_q == FILL);
    assign issue       = in_fill && (issue_cnt < ISS_W'(WORDS_PER_LINE))
                         && (outstanding < OUT_W'(MAX_OUTSTANDING)) && !mem_busy;
    // A return with nothing outstanding is a protocol violation and is dropped
    assign accept      = in_fill && memory_data_valid && (outstanding != '0);
    assign last_accept = accept && (recv_cnt == IDX_W'(WORDS_PER_LINE - 1));
    assign clr_cnt     = (state_q == TAG);

    cache_up_counter #(.W(ISS_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .inc_i (issue),
        .dec_i (1'b0),
        .cnt_o (issue_cnt)
    );

    cache_up_counter #(.W(IDX_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .inc_i (accept),
        .dec_i (1'b0),
        .cnt_o (recv_cnt)
    );

    cache_up_counter #(.W(OUT_W)) u_outstanding (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .inc_i (issue),
        .dec_i (accept),
        .cnt_o (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            line_base_q <= '0;
            tag_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tag_wr_q <= 1'b0;
                    if (miss_detected) begin
                        state_q     <= FILL;
                        line_base_q <= miss_address & LINE_MASK;
                        busy_q      <= 1'b1;
                    end
                end
                FILL: begin
                    if (last_accept) begin
                        state_q  <= TAG;
                        tag_wr_q <= 1'b1;
                    end
                end
                TAG: begin
                    state_q  <= IDLE;
                    tag_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    tag_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Line base is aligned, so base + offset never carries out of the line
    assign memory_address   = line_base_q + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
    assign mem_rd_en        = issue;
    assign write_data_array = accept;
    assign data_word_idx    = recv_cnt;
    assign write_tag_array  = tag_wr_q;
    assign tag_address      = line_base_q;
    assign fsm_busy         = busy_q;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Randomized bench for cache_line_fill_ctrl: in-order latency memory plus a line-fill reference model.
module tb_cache_line_fill_ctrl;

    localparam int AW   = 16;
    localparam int WPL  = 8;
    localparam int WB   = 2;
    localparam int MAXO = 4;
    localparam int LB   = WPL * WB;
    localparam int IW   = (WPL > 1) ? $clog2(WPL) : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_detected = 1'b0;
    logic [AW-1:0] miss_address = '0;
    logic          mem_busy = 1'b0;
    logic          memory_data_valid = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic [IW-1:0] data_word_idx;
    logic          write_tag_array;
    logic [AW-1:0] tag_address;
    logic          fsm_busy;

    cache_line_fill_ctrl #(
        .ADDR_W(AW), .WORDS_PER_LINE(WPL), .WORD_BYTES(WB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_busy          (mem_busy),
        .memory_data_valid (memory_data_valid),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_idx     (data_word_idx),
        .write_tag_array   (write_tag_array),
        .tag_address       (tag_address),
        .fsm_busy          (fsm_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        int            rdy;
    } rd_t;

    rd_t mq[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  busy_pct = 0, spur_pct = 0, lat_min = 1, lat_max = 1, force_busy = 0;
    int  fills_done = 0, tags_seen = 0, last_rdy = 0;

    bit            m_fill = 0, m_tag = 0;
    logic [AW-1:0] m_base = '0;
    int            m_iss = 0, m_rcv = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] word_of(input logic [AW-1:0] a, input logic [AW-1:0] base);
        logic [AW-1:0] d;
        d = a - base;
        return d / AW'(WB);
    endfunction

    task automatic step(input bit miss, input logic [AW-1:0] addr);
        bit exp_rd, exp_wr;
        int out;
        logic [AW-1:0] ea;
        rd_t r;
        @(negedge clk);
        miss_detected = miss;
        miss_address  = addr;
        if (force_busy > 0) begin
            mem_busy = 1'b1;
            force_busy--;
        end else begin
            mem_busy = ($urandom_range(99) < busy_pct);
        end
        if (mq.size() > 0) memory_data_valid = (mq[0].rdy <= cyc);
        else               memory_data_valid = ($urandom_range(99) < spur_pct);
        #1;
        out    = m_iss - m_rcv;
        exp_rd = m_fill && (m_iss < WPL) && (out < MAXO) && !mem_busy;
        exp_wr = m_fill && memory_data_valid && (out > 0);
        chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
        chk("wr_data", 32'(write_data_array), 32'(exp_wr));
        chk("wr_tag", 32'(write_tag_array), 32'(m_tag));
        chk("fsm_busy", 32'(fsm_busy), 32'(m_fill || m_tag));
        if (exp_rd) begin
            ea = m_base + AW'(m_iss * WB);
            chk("mem_addr", 32'(memory_address), 32'(ea));
        end
        if (exp_wr) begin
            chk("word_idx", 32'(data_word_idx), 32'(m_rcv));
            if (mq.size() > 0) chk("word_order", 32'(data_word_idx), 32'(word_of(mq[0].a, m_base)));
        end
        if (m_tag) chk("tag_addr", 32'(tag_address), 32'(m_base));
        if (write_tag_array) tags_seen++;
        // memory side follows what the DUT actually issued
        if (memory_data_valid && mq.size() > 0) void'(mq.pop_front());
        if (mem_rd_en) begin
            r.a   = memory_address;
            r.rdy = cyc + $urandom_range(lat_max, lat_min);
            if (r.rdy < last_rdy) r.rdy = last_rdy;
            last_rdy = r.rdy;
            mq.push_back(r);
        end
        chk("outst_le_max", 32'(mq.size() <= MAXO), 32'd1);
        if (m_tag) begin
            m_tag = 0;
        end else if (m_fill) begin
            if (exp_rd) m_iss++;
            if (exp_wr) begin
                m_rcv++;
                if (m_rcv == WPL) begin
                    m_fill = 0;
                    m_tag  = 1;
                    fills_done++;
                end
            end
        end else if (miss) begin
            m_fill = 1;
            m_base = addr & ~AW'(LB - 1);
            m_iss  = 0;
            m_rcv  = 0;
        end
        cyc++;
    endtask

    task automatic do_fill(input logic [AW-1:0] addr, input bit hold);
        int n;
        step(1'b1, addr);
        n = 0;
        while ((m_fill || m_tag) && n < 3000) begin
            step(hold, hold ? AW'($urandom) : addr);
            n++;
        end
        if (m_fill || m_tag) begin
            chk("fill_timeout", 32'd1, 32'd0);
            m_fill = 0;
            m_tag  = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, AW'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd"},   32'(mem_rd_en), 32'd0);
        chk({tag, "_wr"},   32'(write_data_array), 32'd0);
        chk({tag, "_tag"},  32'(write_tag_array), 32'd0);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        chk({tag, "_addr"}, 32'(memory_address), 32'd0);
        chk({tag, "_taddr"}, 32'(tag_address), 32'd0);
        chk({tag, "_idx"},  32'(data_word_idx), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // 1-cycle memory, clean fill
        do_fill(16'h1233, 1'b0);
        chk("tag_count_1", 32'(tags_seen), 32'd1);

        // stall issue for three cycles mid-fill
        step(1'b1, 16'h2468);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        force_busy = 3;
        while (m_fill || m_tag) step(1'b0, 16'h0);

        // long memory latency exercises the credit limit
        lat_min = 10; lat_max = 10;
        do_fill(16'h4C01, 1'b0);
        lat_min = 1;  lat_max = 1;

        // spurious returns in IDLE and with nothing outstanding
        spur_pct = 100;
        idle_cycles(4);
        spur_pct = 60; busy_pct = 50;
        do_fill(16'h0777, 1'b0);
        spur_pct = 0;  busy_pct = 0;

        // async reset after the third word returns, then a miss at the top of memory
        lat_min = 2; lat_max = 3;
        step(1'b1, 16'hABCD);
        for (int n = 0; n < 200 && m_rcv < 3; n++) step(1'b0, 16'h0);
        @(negedge clk);
        memory_data_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        m_fill = 0; m_tag = 0;
        mq.delete();
        last_rdy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        lat_min = 1; lat_max = 1;
        do_fill(16'hFFFF, 1'b0);

        // miss held high with a wandering address: back-to-back fills
        do_fill(16'h3000, 1'b1);
        do_fill(16'h5A5A, 1'b1);

        // randomized fills
        for (int k = 0; k < 25; k++) begin
            busy_pct = $urandom_range(60);
            spur_pct = $urandom_range(40);
            lat_min  = 1;
            lat_max  = $urandom_range(12, 1);
            do_fill(AW'($urandom), $urandom_range(1));
            idle_cycles($urandom_range(3));
        end

        chk("tag_pulses", 32'(tags_seen), 32'(fills_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
